win_accum: RTL and testbench

//   Parametrised successor to the team's basic running adder. Accumulates an

---
 rtl/win_accum_pkg.sv | 27 ++
 rtl/win_accum_buf.sv | 61 ++++++
 rtl/win_accum.sv | 138 +++++++++++++
 tb/tb_win_accum.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/win_accum_pkg.sv
// Shared definitions for the windowed accumulator: mode encoding and a
// constant-evaluable ceiling-log2 used to size the window sum and pointers.
package win_accum_pkg;

    // Runtime accumulation mode, as presented on the mode input.
    typedef enum logic {
        ModeRun = 1'b0,  // running sum
        ModeWin = 1'b1   // sliding-window sum
    } mode_e;

    localparam logic MODE_RUN = 1'b0;
    localparam logic MODE_WIN = 1'b1;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/win_accum_buf.sv
// Circular sample buffer for the window sum. rdat is the entry the next
// write will overwrite, i.e. the oldest sample once the window is full,
// and zero before that because a clear or reset zeroes every slot.
module win_buf
    import win_accum_pkg::*;
#(
    parameter int unsigned DIN_W = 6,
    parameter int unsigned WIN   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [DIN_W-1:0] wdat,
    output logic [DIN_W-1:0] rdat,
    output logic             full
);

    localparam int unsigned PTR_W  = clog2(WIN);
    localparam int unsigned FILL_W = clog2(WIN + 1);

    logic [DIN_W-1:0]  mem_q [WIN];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [FILL_W-1:0] fill_q;

    // Buffer storage, write pointer and fill count; clr zeroes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else if (clr) begin
            for (int i = 0; i < WIN; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= wdat;
            if (wr_ptr_q == PTR_W'(WIN - 1)) begin
                wr_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fill_q != FILL_W'(WIN)) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    // Oldest-entry read and "window full once this write lands" flag, so the
    // top can qualify the very write that completes the window.
    always_comb begin
        rdat = mem_q[wr_ptr_q];
        full = (fill_q == FILL_W'(WIN)) ||
               (wr_en && (fill_q == FILL_W'(WIN - 1)));
    end

endmodule

// File: rtl/win_accum.sv
// Gated sample accumulator with two runtime modes: running sum with
// saturate/wrap overflow handling, or sliding-window sum over the last WIN
// samples. Output is registered, one cycle after the accepting edge.
module win_accum
    import win_accum_pkg::*;
#(
    parameter int unsigned DIN_W  = 6,
    parameter int unsigned DOUT_W = 8,
    parameter int unsigned WIN    = 4,
    parameter bit          SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIN_W-1:0]  din,
    input  logic              mode,
    input  logic              clr,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_vld,
    output logic              ovf
);

    // Window sum is wide enough for WIN full-scale samples, so it never wraps.
    localparam int unsigned SUM_W = DIN_W + clog2(WIN);
    localparam int unsigned MAX_W = (SUM_W > DOUT_W) ? SUM_W : DOUT_W;

    mode_e             mode_q;
    logic [DOUT_W-1:0] acc_q;
    logic [SUM_W-1:0]  sum_q;
    logic [DOUT_W-1:0] dout_q;
    logic              dout_vld_q;
    logic              ovf_q;

    logic              do_clr;
    logic              accept;
    logic              buf_wr;
    logic [DIN_W-1:0]  buf_rdat;
    logic              buf_full;

    logic [DOUT_W:0]   acc_ext;
    logic              acc_carry;
    logic [DOUT_W-1:0] acc_new;
    logic [SUM_W-1:0]  sum_next;
    logic [MAX_W-1:0]  sum_ext;
    logic              red_ovf;
    logic [DOUT_W-1:0] sum_red;

    // Explicit or mode-change clear; either one drops the sample of that cycle.
    always_comb begin
        do_clr = clr || (mode != logic'(mode_q));
        accept = en && !do_clr;
        buf_wr = accept && (mode_q == ModeWin);
    end

    win_buf #(
        .DIN_W (DIN_W),
        .WIN   (WIN)
    ) u_win_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (do_clr),
        .wr_en (buf_wr),
        .wdat  (din),
        .rdat  (buf_rdat),
        .full  (buf_full)
    );

    // Running-sum adder with one carry bit, and window add/evict with reduction.
    always_comb begin
        acc_ext   = {1'b0, acc_q} + (DOUT_W + 1)'(din);
        acc_carry = acc_ext[DOUT_W];
        if (acc_carry && SAT) begin
            acc_new = '1;
        end else begin
            acc_new = acc_ext[DOUT_W-1:0];
        end

        // Modulo arithmetic is exact here: the evicted sample is part of sum_q.
        sum_next = sum_q + SUM_W'(din) - SUM_W'(buf_rdat);
        sum_ext  = MAX_W'(sum_next);
        red_ovf  = (sum_ext >> DOUT_W) != '0;
        if (red_ovf && SAT) begin
            sum_red = '1;
        end else begin
            sum_red = sum_ext[DOUT_W-1:0];
        end
    end

    // Mode register, accumulators and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= ModeRun;
            acc_q      <= '0;
            sum_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (do_clr) begin
            mode_q     <= mode_e'(mode);
            acc_q      <= '0;
            sum_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (accept) begin
            if (mode_q == ModeRun) begin
                acc_q      <= acc_new;
                dout_q     <= acc_new;
                dout_vld_q <= 1'b1;
                if (acc_carry) begin
                    ovf_q <= 1'b1;
                end
            end else begin
                sum_q <= sum_next;
                // Output only advances once the window holds WIN real samples.
                if (buf_full) begin
                    dout_q     <= sum_red;
                    dout_vld_q <= 1'b1;
                    if (red_ovf) begin
                        ovf_q <= 1'b1;
                    end
                end else begin
                    dout_vld_q <= 1'b0;
                end
            end
        end else begin
            dout_vld_q <= 1'b0;
        end
    end

    // Drive outputs straight from their registers.
    always_comb begin
        dout     = dout_q;
        dout_vld = dout_vld_q;
        ovf      = ovf_q;
    end

endmodule

// File: tb/tb_win_accum.sv
// Directed bench for win_accum with default parameters (SAT=1).
module tb_win_accum;

    localparam int unsigned DIN_W  = 6;
    localparam int unsigned DOUT_W = 8;
    localparam int unsigned WIN    = 4;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [DIN_W-1:0]  din;
    logic              mode;
    logic              clr;
    logic [DOUT_W-1:0] dout;
    logic              dout_vld;
    logic              ovf;

    int errors = 0;
    int checks = 0;

    win_accum #(
        .DIN_W  (DIN_W),
        .DOUT_W (DOUT_W),
        .WIN    (WIN),
        .SAT    (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .din      (din),
        .mode     (mode),
        .clr      (clr),
        .dout     (dout),
        .dout_vld (dout_vld),
        .ovf      (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present inputs for one edge, then settle 1ns past it for sampling.
    task automatic cycle(input logic e, input int d, input logic m, input logic c);
        en   = e;
        din  = DIN_W'(d);
        mode = m;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int run_exp [6] = '{7, 16, 79, 142, 205, 255};
        int run_din [6] = '{7, 9, 63, 63, 63, 63};
        en = 1'b0; din = '0; mode = 1'b0; clr = 1'b0; rst_n = 1'b0;
        #23;
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL reset_dout: got %0d want 0", dout); end
        checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b want 0", dout_vld); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, run_din[i], 1'b0, 1'b0);
            checks++;
            if (dout !== DOUT_W'(run_exp[i])) begin
                errors++; $display("FAIL pre_reset_dout[%0d]: got %0d want %0d", i, dout, run_exp[i]);
            end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL pre_reset_ovf: got %0b want 1", ovf); end
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL async_reset_dout: got %0d want 0", dout); end
        checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL async_reset_vld: got %0b want 0", dout_vld); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL async_reset_ovf: got %0b want 0", ovf); end
        #50;
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL held_reset_dout: got %0d want 0", dout); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 5, 1'b0, 1'b0);
        checks++; if (dout !== 8'd5) begin errors++; $display("FAIL post_reset_dout: got %0d want 5", dout); end
        checks++; if (dout_vld !== 1'b1) begin errors++; $display("FAIL post_reset_vld: got %0b want 1", dout_vld); end
    endtask

    task automatic test_running();
        int exp_sum;
        exp_sum = 0;
        cycle(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, i, 1'b0, 1'b0);
            exp_sum += i;
            checks++;
            if (dout_vld !== 1'b1) begin
                errors++; $display("FAIL running_vld[%0d]: got %0b want 1", i, dout_vld);
            end
            checks++;
            if (dout !== DOUT_W'(exp_sum)) begin
                errors++; $display("FAIL running_dout[%0d]: got %0d want %0d", i, dout, exp_sum);
            end
        end
        checks++; if (dout !== 8'd120) begin errors++; $display("FAIL running_final: got %0d want 120", dout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL running_ovf: got %0b want 0", ovf); end
    endtask

    task automatic test_overflow();
        int exp_d [5] = '{63, 126, 189, 252, 255};
        int exp_o [5] = '{0, 0, 0, 0, 1};
        cycle(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 63, 1'b0, 1'b0);
            checks++;
            if (dout !== DOUT_W'(exp_d[i])) begin
                errors++; $display("FAIL ovf_dout[%0d]: got %0d want %0d", i, dout, exp_d[i]);
            end
            checks++;
            if (ovf !== exp_o[i][0]) begin
                errors++; $display("FAIL ovf_flag[%0d]: got %0b want %0d", i, ovf, exp_o[i]);
            end
        end
    endtask

    task automatic test_window();
        int w_din [10] = '{1, 2, 3, 4, 5, 6, 63, 63, 63, 63};
        int w_vld [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        int w_exp [10] = '{0, 0, 0, 10, 14, 18, 78, 137, 195, 252};
        // Switching to window mode clears, which also drops the sticky ovf.
        cycle(1'b0, 0, 1'b1, 1'b0);
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL win_clear_dout: got %0d want 0", dout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL win_clear_ovf: got %0b want 0", ovf); end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, w_din[i], 1'b1, 1'b0);
            checks++;
            if (dout_vld !== w_vld[i][0]) begin
                errors++; $display("FAIL win_vld[%0d]: got %0b want %0d", i, dout_vld, w_vld[i]);
            end
            if (w_vld[i] != 0) begin
                checks++;
                if (dout !== DOUT_W'(w_exp[i])) begin
                    errors++; $display("FAIL win_dout[%0d]: got %0d want %0d", i, dout, w_exp[i]);
                end
            end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL win_ovf: got %0b want 0", ovf); end
    endtask

    task automatic test_gaps();
        cycle(1'b0, 0, 1'b0, 1'b0);
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL gap_modeclr_dout: got %0d want 0", dout); end
        cycle(1'b1, 10, 1'b0, 1'b0);
        checks++; if (dout !== 8'd10) begin errors++; $display("FAIL gap_first: got %0d want 10", dout); end
        cycle(1'b0, 33, 1'b0, 1'b0);
        checks++; if (dout !== 8'd10) begin errors++; $display("FAIL gap_hold_dout: got %0d want 10", dout); end
        checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL gap_hold_vld: got %0b want 0", dout_vld); end
        cycle(1'b1, 20, 1'b0, 1'b0);
        checks++; if (dout !== 8'd30) begin errors++; $display("FAIL gap_resume: got %0d want 30", dout); end
        checks++; if (dout_vld !== 1'b1) begin errors++; $display("FAIL gap_resume_vld: got %0b want 1", dout_vld); end
        for (int i = 0; i < 4; i++) cycle(1'b1, 63, 1'b0, 1'b0);
        checks++; if (dout !== 8'd255) begin errors++; $display("FAIL gap_sat: got %0d want 255", dout); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL gap_ovf_set: got %0b want 1", ovf); end
        cycle(1'b1, 9, 1'b0, 1'b1);
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL clr_dout: got %0d want 0", dout); end
        checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL clr_vld: got %0b want 0", dout_vld); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %0b want 0", ovf); end
        cycle(1'b1, 4, 1'b0, 1'b0);
        checks++; if (dout !== 8'd4) begin errors++; $display("FAIL clr_dropped: got %0d want 4", dout); end
    endtask

    task automatic test_mode_switch();
        int s_vld [4] = '{0, 0, 0, 1};
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b1, 1, 1'b0, 1'b0);
        cycle(1'b1, 2, 1'b0, 1'b0);
        cycle(1'b1, 3, 1'b0, 1'b0);
        checks++; if (dout !== 8'd6) begin errors++; $display("FAIL sw_run_dout: got %0d want 6", dout); end
        cycle(1'b1, 50, 1'b1, 1'b0);
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL sw_clear_dout: got %0d want 0", dout); end
        checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL sw_clear_vld: got %0b want 0", dout_vld); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, i + 1, 1'b1, 1'b0);
            checks++;
            if (dout_vld !== s_vld[i][0]) begin
                errors++; $display("FAIL sw_refill_vld[%0d]: got %0b want %0d", i, dout_vld, s_vld[i]);
            end
        end
        checks++; if (dout !== 8'd10) begin errors++; $display("FAIL sw_refill_dout: got %0d want 10", dout); end
    endtask

    initial begin
        test_reset();
        test_running();
        test_overflow();
        test_window();
        test_gaps();
        test_mode_switch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
